// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS inter-stage pipeline registers.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_ONE   = ST_ONE,
    S_TWO   = ST_TWO
  } stage_state_e;

  localparam logic [31:0] MIPS_NOP = 32'h0000_0000;

  // Payload widths of the four stage boundaries
  localparam int unsigned IFID_W  = 64;
  localparam int unsigned IDEX_W  = 147;
  localparam int unsigned EXMEM_W = 107;
  localparam int unsigned MEMWB_W = 71;

endpackage

// File: rtl/pipe_stage_stats.sv
// Saturating stall / flush event counters for one pipeline stage register.
module pipe_stage_stats #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_i,
  input  logic             flush_hit_i,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Increment on event, hold at all-ones
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (stall_i && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + CNT_W'(1);
    if (flush_hit_i && (flush_q != {CNT_W{1'b1}})) flush_d = flush_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer and synchronous flush.
// Define PIPE_STAGE_STATS_EN to add the stall_cnt / flush_cnt statistics ports.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W    = IFID_W,
  parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(MIPS_NOP),
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
`endif
);

  if ((DATA_W == 0) || (CNT_W == 0)) begin : g_param_chk
    $error("pipe_stage_reg: DATA_W and CNT_W must be non-zero");
  end

  stage_state_e      state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  // Occupancy FSM and main/skid steering; flush overrides every transfer
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      S_EMPTY: begin
        if (in_xfer) begin
          state_d = S_ONE;
          main_d  = in_data;
        end
      end
      S_ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = in_data;
        end else if (in_xfer) begin
          state_d = S_TWO;
          skid_d  = in_data;
        end else if (out_xfer) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (out_xfer) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    if (flush) begin
      state_d = S_EMPTY;
      main_d  = RESET_VAL;
    end
  end

  // Handshake flags are registered from next state so ready never depends on out_ready combinationally
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != S_TWO);
      out_valid_q <= (state_d != S_EMPTY);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

`ifdef PIPE_STAGE_STATS_EN
  pipe_stage_stats #(
    .CNT_W (CNT_W)
  ) u_stats (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (out_valid_q & ~out_ready),
    .flush_hit_i (flush & out_valid_q),
    .stall_cnt_o (stall_cnt),
    .flush_cnt_o (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: directed handshake, backpressure, flush and reset vectors.
module tb_pipe_stage_reg;

  localparam int unsigned       DATA_W    = 64;
  localparam logic [DATA_W-1:0] RESET_VAL = 64'h0000_0000_DEAD_BEEF;
  localparam int unsigned       CNT_W     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
`ifdef PIPE_STAGE_STATS_EN
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W    (DATA_W),
    .RESET_VAL (RESET_VAL),
    .CNT_W     (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STAGE_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .flush_cnt (flush_cnt)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic expect_out);
    in_valid = 1'b1;
    in_data  = d;
    if (expect_out) exp_q.push_back(d);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // Monitor: every downstream transfer pops the oldest expected payload
    fork
      forever begin
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got %h, required no output", out_data);
          end else begin
            check("sb_data", out_data, exp_q.pop_front());
          end
        end
      end
    join_none

    // Reset
    step(); step();
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_data", out_data, RESET_VAL);
`ifdef PIPE_STAGE_STATS_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'(0));
    check("rst_flush_cnt", 64'(flush_cnt), 64'(0));
`endif
    rst = 1'b0;

    // Stream: one cycle latency, full throughput
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      push(64'(i), 1'b1);
      step();
      check("stream_in_ready", 64'(in_ready), 64'(1));
      check("stream_out_valid", 64'(out_valid), 64'(1));
      check("stream_out_data", out_data, 64'(i));
    end
    in_valid = 1'b0;
    step();
    check("stream_drained", 64'(out_valid), 64'(0));

    // Backpressure: fill main and skid, hold third entry upstream
    out_ready = 1'b0;
    push(64'hA, 1'b1);
    step();
    check("bp_a_ready", 64'(in_ready), 64'(1));
    check("bp_a_data", out_data, 64'hA);
    push(64'hB, 1'b1);
    step();
    check("bp_b_ready", 64'(in_ready), 64'(0));
    check("bp_b_hold", out_data, 64'hA);
    push(64'hC, 1'b1);
    step();
    check("bp_c_ready", 64'(in_ready), 64'(0));
    check("bp_c_hold", out_data, 64'hA);
    step();
    check("bp_hold2", out_data, 64'hA);
`ifdef PIPE_STAGE_STATS_EN
    check("bp_stall_cnt", 64'(stall_cnt), 64'(3));
`endif
    out_ready = 1'b1;
    step();
    check("bp_rel_b", out_data, 64'hB);
    check("bp_rel_ready", 64'(in_ready), 64'(1));
    step();
    check("bp_rel_c", out_data, 64'hC);
    in_valid = 1'b0;
    step();
    check("bp_drained", 64'(out_valid), 64'(0));

    // Flush while full with a pending upstream entry
    out_ready = 1'b0;
    push(64'hE, 1'b0);
    step();
    push(64'hF, 1'b0);
    step();
    check("fl_full", 64'(in_ready), 64'(0));
    push(64'hD, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 64'(out_valid), 64'(0));
    check("fl_in_ready", 64'(in_ready), 64'(1));
    check("fl_out_data", out_data, RESET_VAL);
`ifdef PIPE_STAGE_STATS_EN
    check("fl_flush_cnt", 64'(flush_cnt), 64'(1));
`endif

    // Flush in ONE discards a simultaneous accepted input
    push(64'h16, 1'b0);
    step();
    push(64'h17, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("fl1_out_valid", 64'(out_valid), 64'(0));
    step();
    check("fl1_discard", 64'(out_valid), 64'(0));
    // Flush of an empty stage kills nothing
    flush = 1'b1;
    step();
    flush = 1'b0;
`ifdef PIPE_STAGE_STATS_EN
    check("fl_empty_cnt", 64'(flush_cnt), 64'(2));
`endif

    // Reset and flush together while holding two entries
    push(64'h21, 1'b0);
    step();
    push(64'h22, 1'b0);
    step();
    in_valid = 1'b0;
    rst = 1'b1; flush = 1'b1;
    step();
    rst = 1'b0; flush = 1'b0;
    check("rf_out_valid", 64'(out_valid), 64'(0));
    check("rf_in_ready", 64'(in_ready), 64'(1));
    check("rf_out_data", out_data, RESET_VAL);
`ifdef PIPE_STAGE_STATS_EN
    check("rf_flush_cnt", 64'(flush_cnt), 64'(0));
    check("rf_stall_cnt", 64'(stall_cnt), 64'(0));
`endif

    // Long stall saturates the stall counter
    push(64'h30, 1'b1);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check("sat_hold", out_data, 64'h30);
`ifdef PIPE_STAGE_STATS_EN
    check("sat_stall_cnt", 64'(stall_cnt), 64'(15));
`endif
    out_ready = 1'b1;
    step();
    check("sat_drained", 64'(out_valid), 64'(0));
    step();

    check("sb_empty", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
